// File: rtl/touch_adc_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | touch_adc_responder : serial touch-ADC slave (8-bit command, busy, 12-bit |
// | result), all pins synchronized into the cclk domain.  Revision: 1.0       |
// +--------------------------------------------------------------------------+
module touch_adc_responder #(
  parameter int BUSY_CLKS = 1
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        touch_csb,
  input  logic        touch_clk,
  input  logic        data_in,
  output logic        data_out,
  output logic        touch_busy,
  input  logic [11:0] x_val,
  input  logic [11:0] y_val,
  input  logic [11:0] z_val,
  output logic        cmd_strobe,
  output logic [7:0]  last_cmd,
  output logic        bad_chan
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  localparam logic [2:0] BUSY_LAST = 3'(BUSY_CLKS);

  // Stage [0] is the first flop; edges compare stage [1] against stage [2].
  logic [1:0]  csb_sync_q;
  logic [2:0]  sclk_sync_q;
  logic [1:0]  din_sync_q;

  logic [1:0]  state_q,    state_d;
  logic [6:0]  shift_q,    shift_d;
  logic [3:0]  bit_cnt_q,  bit_cnt_d;
  logic [2:0]  busy_cnt_q, busy_cnt_d;
  logic [3:0]  idx_q,      idx_d;
  logic [11:0] result_q,   result_d;
  logic        dout_q,     dout_d;
  logic        busy_q,     busy_d;
  logic        strobe_q,   strobe_d;
  logic [7:0]  last_cmd_q, last_cmd_d;
  logic        bad_q,      bad_d;

  logic        w_csb_hi;
  logic        w_din;
  logic        w_rise;
  logic        w_fall;
  logic [7:0]  w_cmd_next;
  logic        w_next_bad;
  logic [11:0] w_sel_val;
  logic [3:0]  w_idx_dn;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      csb_sync_q  <= 2'b11;
      sclk_sync_q <= 3'b000;
      din_sync_q  <= 2'b00;
    end else begin
      csb_sync_q  <= {csb_sync_q[0], touch_csb};
      sclk_sync_q <= {sclk_sync_q[1:0], touch_clk};
      din_sync_q  <= {din_sync_q[0], data_in};
    end
  end

  assign w_csb_hi   = csb_sync_q[1];
  assign w_din      = din_sync_q[1];
  assign w_rise     = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign w_fall     = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign w_cmd_next = {shift_q, w_din};
  assign w_idx_dn   = idx_q - 4'd1;

  always_comb begin
    w_next_bad = 1'b1;
    case (w_cmd_next[6:4])
      3'b101, 3'b001, 3'b011: w_next_bad = 1'b0;
      default:                w_next_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_sel_val = 12'h000;
    case (last_cmd_q[6:4])
      3'b101:  w_sel_val = x_val;
      3'b001:  w_sel_val = y_val;
      3'b011:  w_sel_val = z_val;
      default: w_sel_val = 12'h000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    busy_cnt_d = busy_cnt_q;
    idx_d      = idx_q;
    result_d   = result_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    strobe_d   = 1'b0;
    last_cmd_d = last_cmd_q;
    bad_d      = bad_q;

    // Deselect overrides any edge seen in the same cycle.
    if (w_csb_hi) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      dout_d     = 1'b0;
      bit_cnt_d  = 4'd0;
      busy_cnt_d = 3'd0;
      idx_d      = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_rise && w_din) begin
            shift_d   = 7'h01;
            bit_cnt_d = 4'd1;
            state_d   = ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_rise) begin
            shift_d = w_cmd_next[6:0];
            if (bit_cnt_q == 4'd7) begin
              last_cmd_d = w_cmd_next;
              bad_d      = w_next_bad;
              strobe_d   = 1'b1;
              bit_cnt_d  = 4'd0;
              busy_cnt_d = 3'd0;
              state_d    = ST_BUSY;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_BUSY: begin
          if (w_fall) begin
            if (busy_cnt_q == 3'd0) begin
              busy_d     = 1'b1;
              result_d   = w_sel_val;
              busy_cnt_d = 3'd1;
            end else if (busy_cnt_q == BUSY_LAST) begin
              busy_d  = 1'b0;
              dout_d  = result_q[11];
              idx_d   = 4'd11;
              state_d = ST_DATA;
            end else begin
              busy_cnt_d = busy_cnt_q + 3'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_fall) begin
            if (idx_q == 4'd0) begin
              dout_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              idx_d  = w_idx_dn;
              dout_d = result_q[w_idx_dn];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      shift_q    <= 7'h00;
      bit_cnt_q  <= 4'd0;
      busy_cnt_q <= 3'd0;
      idx_q      <= 4'd0;
      result_q   <= 12'h000;
      dout_q     <= 1'b0;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      last_cmd_q <= 8'h00;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_cnt_q <= busy_cnt_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      strobe_q   <= strobe_d;
      last_cmd_q <= last_cmd_d;
      bad_q      <= bad_d;
    end
  end

  assign data_out   = dout_q;
  assign touch_busy = busy_q;
  assign cmd_strobe = strobe_q;
  assign last_cmd   = last_cmd_q;
  assign bad_chan   = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_touch_adc_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_touch_adc_responder : directed bench for touch_adc_responder.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_touch_adc_responder;

  logic        cclk = 1'b0;
  logic        rstb = 1'b0;
  logic        touch_csb = 1'b1;
  logic        touch_clk = 1'b0;
  logic        data_in = 1'b0;
  logic [11:0] x_val = 12'h000;
  logic [11:0] y_val = 12'h000;
  logic [11:0] z_val = 12'h000;

  logic        dout_a, busy_a, strobe_a, bad_a;
  logic [7:0]  last_a;
  logic        dout_b, busy_b, strobe_b, bad_b;
  logic [7:0]  last_b;

  logic        sel = 1'b0;
  int          strobes = 0;
  int          vectors = 0;
  int          errors = 0;

  logic        w_dout, w_busy, w_bad, w_strobe;
  logic [7:0]  w_last;

  touch_adc_responder #(.BUSY_CLKS(1)) dut_a (
    .cclk(cclk), .rstb(rstb), .touch_csb(touch_csb), .touch_clk(touch_clk),
    .data_in(data_in), .data_out(dout_a), .touch_busy(busy_a),
    .x_val(x_val), .y_val(y_val), .z_val(z_val),
    .cmd_strobe(strobe_a), .last_cmd(last_a), .bad_chan(bad_a)
  );

  touch_adc_responder #(.BUSY_CLKS(3)) dut_b (
    .cclk(cclk), .rstb(rstb), .touch_csb(touch_csb), .touch_clk(touch_clk),
    .data_in(data_in), .data_out(dout_b), .touch_busy(busy_b),
    .x_val(x_val), .y_val(y_val), .z_val(z_val),
    .cmd_strobe(strobe_b), .last_cmd(last_b), .bad_chan(bad_b)
  );

  assign w_dout   = sel ? dout_b   : dout_a;
  assign w_busy   = sel ? busy_b   : busy_a;
  assign w_bad    = sel ? bad_b    : bad_a;
  assign w_strobe = sel ? strobe_b : strobe_a;
  assign w_last   = sel ? last_b   : last_a;

  always #5 cclk = ~cclk;

  always @(posedge cclk) begin
    if (w_strobe === 1'b1) strobes <= strobes + 1;
  end

  // One serial clock: all stimulus lands on multiples of 10 ns, clear of cclk rising edges.
  task automatic tick(input logic d);
    data_in = d;
    #20 touch_clk = 1'b1;
    #40 touch_clk = 1'b0;
    #40;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) tick(c[i]);
  endtask

  task automatic start_frame;
    touch_csb = 1'b0;
    #50;
  endtask

  task automatic end_frame;
    touch_csb = 1'b1;
    #50;
  endtask

  task automatic get_frame(output logic [11:0] val, output int busy_n, output logic tail);
    busy_n = 0;
    for (int g = 0; g < 8 && w_busy === 1'b1; g++) begin
      busy_n++;
      tick(1'b0);
    end
    for (int i = 11; i >= 0; i--) begin
      val[i] = w_dout;
      if (i > 0) tick(1'b0);
    end
    tick(1'b0);
    tail = w_dout;
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    #30;
    vectors++; if (dout_a !== 1'b0)   begin errors++; $display("FAIL reset_dout got %b want 0", dout_a); end
    vectors++; if (busy_a !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    vectors++; if (strobe_a !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", strobe_a); end
    vectors++; if (last_a !== 8'h00)  begin errors++; $display("FAIL reset_last_cmd got %h want 00", last_a); end
    vectors++; if (bad_a !== 1'b0)    begin errors++; $display("FAIL reset_bad_chan got %b want 0", bad_a); end
    rstb = 1'b1;
    #20;
  endtask

  task automatic test_basic;
    logic [11:0] val; int bn; logic tail; int s0;
    sel = 1'b0; x_val = 12'hA5C;
    s0 = strobes;
    start_frame();
    send_cmd(8'hD0);
    vectors++; if (strobes - s0 !== 1) begin errors++; $display("FAIL basic_strobe_count got %0d want 1", strobes - s0); end
    vectors++; if (w_last !== 8'hD0)   begin errors++; $display("FAIL basic_last_cmd got %h want D0", w_last); end
    vectors++; if (w_bad !== 1'b0)     begin errors++; $display("FAIL basic_bad_chan got %b want 0", w_bad); end
    get_frame(val, bn, tail);
    vectors++; if (bn !== 1)           begin errors++; $display("FAIL basic_busy_edges got %0d want 1", bn); end
    vectors++; if (val !== 12'hA5C)    begin errors++; $display("FAIL basic_dout got %h want A5C", val); end
    vectors++; if (tail !== 1'b0)      begin errors++; $display("FAIL basic_tail got %b want 0", tail); end
    vectors++; if (strobes - s0 !== 1) begin errors++; $display("FAIL basic_strobe_total got %0d want 1", strobes - s0); end
    end_frame();
  endtask

  task automatic test_busy3;
    logic [11:0] val; int bn; logic tail; int s0;
    sel = 1'b1; y_val = 12'h3E8;
    s0 = strobes;
    start_frame();
    send_cmd(8'h90);
    vectors++; if (strobes - s0 !== 1) begin errors++; $display("FAIL busy3_strobe_count got %0d want 1", strobes - s0); end
    get_frame(val, bn, tail);
    vectors++; if (bn !== 3)           begin errors++; $display("FAIL busy3_busy_edges got %0d want 3", bn); end
    vectors++; if (val !== 12'h3E8)    begin errors++; $display("FAIL busy3_dout got %h want 3E8", val); end
    vectors++; if (tail !== 1'b0)      begin errors++; $display("FAIL busy3_tail got %b want 0", tail); end
    end_frame();
    sel = 1'b0;
  endtask

  task automatic test_bad_chan;
    logic [11:0] val; int bn; logic tail;
    sel = 1'b0; z_val = 12'hE00;
    start_frame();
    send_cmd(8'hF0);
    vectors++; if (w_bad !== 1'b1)    begin errors++; $display("FAIL badchan_flag got %b want 1", w_bad); end
    get_frame(val, bn, tail);
    vectors++; if (val !== 12'h000)   begin errors++; $display("FAIL badchan_dout got %h want 000", val); end
    end_frame();
    start_frame();
    send_cmd(8'hB0);
    vectors++; if (w_bad !== 1'b0)    begin errors++; $display("FAIL zchan_flag got %b want 0", w_bad); end
    get_frame(val, bn, tail);
    vectors++; if (val !== 12'hE00)   begin errors++; $display("FAIL zchan_dout got %h want E00", val); end
    end_frame();
  endtask

  task automatic test_capture;
    logic [11:0] val; int bn; logic tail;
    sel = 1'b0; x_val = 12'h111;
    start_frame();
    send_cmd(8'hD0);
    vectors++; if (w_busy !== 1'b1)   begin errors++; $display("FAIL capture_busy got %b want 1", w_busy); end
    x_val = 12'h222;
    get_frame(val, bn, tail);
    vectors++; if (val !== 12'h111)   begin errors++; $display("FAIL capture_dout got %h want 111", val); end
    end_frame();
  endtask

  task automatic test_abort;
    logic [11:0] val; int bn; logic tail;
    sel = 1'b0; x_val = 12'hA5C;
    start_frame();
    send_cmd(8'hD0);
    for (int g = 0; g < 8 && w_busy === 1'b1; g++) tick(1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0);
    vectors++; if (w_dout !== 1'b1)   begin errors++; $display("FAIL abort_bit6 got %b want 1", w_dout); end
    touch_csb = 1'b1;
    #30;
    vectors++; if (w_dout !== 1'b0)   begin errors++; $display("FAIL abort_dout got %b want 0", w_dout); end
    vectors++; if (w_busy !== 1'b0)   begin errors++; $display("FAIL abort_busy got %b want 0", w_busy); end
    vectors++; if (w_last !== 8'hD0)  begin errors++; $display("FAIL abort_last_hold got %h want D0", w_last); end
    #20;
    start_frame();
    send_cmd(8'hD0);
    get_frame(val, bn, tail);
    vectors++; if (val !== 12'hA5C)   begin errors++; $display("FAIL abort_next_dout got %h want A5C", val); end
    end_frame();
  endtask

  task automatic test_reset_midframe;
    logic [11:0] val; int bn; logic tail; int s0;
    sel = 1'b0; x_val = 12'hA5C;
    start_frame();
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1);
    rstb = 1'b0;
    #30;
    vectors++; if (w_last !== 8'h00)  begin errors++; $display("FAIL midrst_last_cmd got %h want 00", w_last); end
    rstb = 1'b1;
    #50;
    s0 = strobes;
    tick(1'b0); tick(1'b0); tick(1'b0);
    send_cmd(8'hD0);
    vectors++; if (strobes - s0 !== 1) begin errors++; $display("FAIL midrst_strobe_count got %0d want 1", strobes - s0); end
    vectors++; if (w_last !== 8'hD0)  begin errors++; $display("FAIL midrst_last_cmd_after got %h want D0", w_last); end
    get_frame(val, bn, tail);
    vectors++; if (val !== 12'hA5C)   begin errors++; $display("FAIL midrst_dout got %h want A5C", val); end
    end_frame();
  endtask

  task automatic test_csb_high_ignored;
    int s0;
    sel = 1'b0;
    s0 = strobes;
    send_cmd(8'hB0);
    #30;
    vectors++; if (strobes - s0 !== 0) begin errors++; $display("FAIL csbhigh_strobe got %0d want 0", strobes - s0); end
    vectors++; if (w_last !== 8'hD0)  begin errors++; $display("FAIL csbhigh_last_cmd got %h want D0", w_last); end
    vectors++; if (w_busy !== 1'b0)   begin errors++; $display("FAIL csbhigh_busy got %b want 0", w_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy3();
    test_bad_chan();
    test_capture();
    test_abort();
    test_reset_midframe();
    test_csb_high_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
